// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants init, refresh, write and read one at a time onto the pins.
// Optional macro SDRAM_ARBIT_RR_EN makes write and read alternate when both request.

module sdram_arbit #(
   parameter logic [3:0] CMD_NOP     = 4'b0111,
   parameter int         DQ_W        = 16,
   parameter int         ADDR_W      = 13,
   parameter int         TIMEOUT_CYC = 1023
) (
   input  logic              i_sysclk,
   input  logic              i_sysrst,
   input  logic              i_init_done,
   input  logic [3:0]        i_init_cmd,
   input  logic [1:0]        i_init_ba,
   input  logic [ADDR_W-1:0] i_init_addr,
   input  logic              i_aref_req,
   input  logic [3:0]        i_aref_cmd,
   input  logic [1:0]        i_aref_ba,
   input  logic [ADDR_W-1:0] i_aref_addr,
   input  logic              i_aref_done,
   output logic              o_aref_en,
   input  logic              i_wr_req,
   input  logic [3:0]        i_wr_cmd,
   input  logic [1:0]        i_wr_ba,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DQ_W-1:0]   i_wr_data,
   input  logic              i_wr_dq_oe,
   input  logic              i_wr_done,
   output logic              o_wr_en,
   input  logic              i_rd_req,
   input  logic [3:0]        i_rd_cmd,
   input  logic [1:0]        i_rd_ba,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic              i_rd_done,
   output logic              o_rd_en,
   output logic [DQ_W-1:0]   o_rd_dq,
   output logic              o_sdram_cke,
   output logic              o_sdram_cs_n,
   output logic              o_sdram_ras_n,
   output logic              o_sdram_cas_n,
   output logic              o_sdram_we_n,
   output logic [1:0]        o_sdram_ba,
   output logic [ADDR_W-1:0] o_sdram_addr,
   output logic [1:0]        o_sdram_dqm,
   inout  wire  [DQ_W-1:0]   io_sdram_dq,
   output logic              o_timeout_err
);

   typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

   localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYC - 1);

   state_t      state;
   logic [9:0]  wdog;
   logic        wr_first;
   logic        grant_wr;
   logic        grant_rd;
   logic        owner_done;
   logic        wd_expired;
   logic [3:0]  cmd;

`ifdef SDRAM_ARBIT_RR_EN
   // Last-served flag; refresh grants leave it untouched.
   logic last_rd;

   always_ff @(posedge i_sysclk or posedge i_sysrst) begin
      if (i_sysrst) begin
         last_rd <= 1'b1;
      end else if (state == ARBIT && i_init_done) begin
         if (grant_wr)
            last_rd <= 1'b0;
         else if (grant_rd)
            last_rd <= 1'b1;
      end
   end

   assign wr_first = last_rd;
`else
   assign wr_first = 1'b1;
`endif

   always_comb begin
      grant_wr = !i_aref_req && i_wr_req && (!i_rd_req || wr_first);
      grant_rd = !i_aref_req && i_rd_req && !grant_wr;
   end

   // Only the current owner's done pulse can close a grant.
   always_comb begin
      owner_done = 1'b0;
      case (state)
         AREF:    owner_done = i_aref_done;
         WRITE:   owner_done = i_wr_done;
         READ:    owner_done = i_rd_done;
         default: owner_done = 1'b0;
      endcase
   end

   assign wd_expired = (wdog == WD_LAST);

   always_ff @(posedge i_sysclk or posedge i_sysrst) begin
      if (i_sysrst) begin
         state         <= INIT;
         o_aref_en     <= 1'b0;
         o_wr_en       <= 1'b0;
         o_rd_en       <= 1'b0;
         o_sdram_cke   <= 1'b0;
         o_timeout_err <= 1'b0;
         wdog          <= '0;
      end else begin
         o_sdram_cke <= 1'b1;
         if (state != INIT && !i_init_done) begin
            state     <= INIT;
            o_aref_en <= 1'b0;
            o_wr_en   <= 1'b0;
            o_rd_en   <= 1'b0;
         end else begin
            case (state)
               INIT: begin
                  if (i_init_done)
                     state <= ARBIT;
               end
               ARBIT: begin
                  wdog <= '0;
                  if (i_aref_req) begin
                     state     <= AREF;
                     o_aref_en <= 1'b1;
                  end else if (grant_wr) begin
                     state   <= WRITE;
                     o_wr_en <= 1'b1;
                  end else if (grant_rd) begin
                     state   <= READ;
                     o_rd_en <= 1'b1;
                  end
               end
               default: begin
                  // Grant ends on the owner's done or when the watchdog runs out.
                  if (owner_done || wd_expired) begin
                     state     <= ARBIT;
                     o_aref_en <= 1'b0;
                     o_wr_en   <= 1'b0;
                     o_rd_en   <= 1'b0;
                     if (!owner_done)
                        o_timeout_err <= 1'b1;
                  end else begin
                     wdog <= wdog + 10'd1;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      cmd          = CMD_NOP;
      o_sdram_ba   = '0;
      o_sdram_addr = '0;
      case (state)
         INIT: begin
            cmd          = i_init_cmd;
            o_sdram_ba   = i_init_ba;
            o_sdram_addr = i_init_addr;
         end
         AREF: begin
            cmd          = i_aref_cmd;
            o_sdram_ba   = i_aref_ba;
            o_sdram_addr = i_aref_addr;
         end
         WRITE: begin
            cmd          = i_wr_cmd;
            o_sdram_ba   = i_wr_ba;
            o_sdram_addr = i_wr_addr;
         end
         READ: begin
            cmd          = i_rd_cmd;
            o_sdram_ba   = i_rd_ba;
            o_sdram_addr = i_rd_addr;
         end
         default: begin
            cmd = CMD_NOP;
         end
      endcase
   end

   assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = cmd;
   assign o_sdram_dqm = 2'b00;
   assign io_sdram_dq = (state == WRITE && i_wr_dq_oe) ? i_wr_data : {DQ_W{1'bz}};
   assign o_rd_dq     = io_sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus randomized traffic against an ownership model.
// Build with +define+SDRAM_ARBIT_RR_EN to check the alternating write/read policy.

module tb_sdram_arbit;

   localparam int TO = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        init_done;
   logic [3:0]  init_cmd;
   logic [1:0]  init_ba;
   logic [12:0] init_addr;
   logic        aref_req, aref_done, aref_en;
   logic [3:0]  aref_cmd;
   logic [1:0]  aref_ba;
   logic [12:0] aref_addr;
   logic        wr_req, wr_done, wr_en, wr_dq_oe;
   logic [3:0]  wr_cmd;
   logic [1:0]  wr_ba;
   logic [12:0] wr_addr;
   logic [15:0] wr_data;
   logic        rd_req, rd_done, rd_en;
   logic [3:0]  rd_cmd;
   logic [1:0]  rd_ba;
   logic [12:0] rd_addr;
   logic [15:0] rd_dq;
   logic        cke, cs_n, ras_n, cas_n, we_n, terr;
   logic [1:0]  ba, dqm;
   logic [12:0] addr;
   wire  [15:0] dq;

   int checks = 0;
   int errors = 0;

   wire [2:0]  ens  = {aref_en, wr_en, rd_en};
   wire [18:0] pins = {cs_n, ras_n, cas_n, we_n, ba, addr};

   sdram_arbit #(.CMD_NOP(4'b0111), .DQ_W(16), .ADDR_W(13), .TIMEOUT_CYC(TO)) dut (
      .i_sysclk(clk), .i_sysrst(rst), .i_init_done(init_done),
      .i_init_cmd(init_cmd), .i_init_ba(init_ba), .i_init_addr(init_addr),
      .i_aref_req(aref_req), .i_aref_cmd(aref_cmd), .i_aref_ba(aref_ba),
      .i_aref_addr(aref_addr), .i_aref_done(aref_done), .o_aref_en(aref_en),
      .i_wr_req(wr_req), .i_wr_cmd(wr_cmd), .i_wr_ba(wr_ba), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_wr_dq_oe(wr_dq_oe), .i_wr_done(wr_done), .o_wr_en(wr_en),
      .i_rd_req(rd_req), .i_rd_cmd(rd_cmd), .i_rd_ba(rd_ba), .i_rd_addr(rd_addr),
      .i_rd_done(rd_done), .o_rd_en(rd_en), .o_rd_dq(rd_dq),
      .o_sdram_cke(cke), .o_sdram_cs_n(cs_n), .o_sdram_ras_n(ras_n),
      .o_sdram_cas_n(cas_n), .o_sdram_we_n(we_n), .o_sdram_ba(ba),
      .o_sdram_addr(addr), .o_sdram_dqm(dqm), .io_sdram_dq(dq),
      .o_timeout_err(terr)
   );

   // Reference model: who owns the bus, how long they have held it, sticky error.
   typedef enum int {M_INIT, M_IDLE, M_AREF, M_WR, M_RD} owner_t;
   owner_t      m_owner;
   int          m_age;
   logic        m_err, m_cke, m_last_rd, m_done;
   logic [2:0]  exp_en;
   logic [18:0] exp_pins;

   always @* begin
      m_done = (m_owner == M_AREF && aref_done) || (m_owner == M_WR && wr_done) ||
               (m_owner == M_RD && rd_done);
      exp_en = {m_owner == M_AREF, m_owner == M_WR, m_owner == M_RD};
      case (m_owner)
         M_INIT:  exp_pins = {init_cmd, init_ba, init_addr};
         M_AREF:  exp_pins = {aref_cmd, aref_ba, aref_addr};
         M_WR:    exp_pins = {wr_cmd, wr_ba, wr_addr};
         M_RD:    exp_pins = {rd_cmd, rd_ba, rd_addr};
         default: exp_pins = {4'b0111, 2'b00, 13'h0000};
      endcase
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner   <= M_INIT;
         m_age     <= 0;
         m_err     <= 1'b0;
         m_cke     <= 1'b0;
         m_last_rd <= 1'b1;
      end else begin
         m_cke <= 1'b1;
         if (m_owner != M_INIT && !init_done) begin
            m_owner <= M_INIT;
         end else if (m_owner == M_INIT) begin
            if (init_done) m_owner <= M_IDLE;
         end else if (m_owner == M_IDLE) begin
            m_age <= 0;
            if (aref_req) begin
               m_owner <= M_AREF;
            end else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
               m_owner   <= m_last_rd ? M_WR : M_RD;
               m_last_rd <= !m_last_rd;
`else
               m_owner <= M_WR;
`endif
            end else if (wr_req) begin
               m_owner   <= M_WR;
               m_last_rd <= 1'b0;
            end else if (rd_req) begin
               m_owner   <= M_RD;
               m_last_rd <= 1'b1;
            end
         end else begin
            if (m_done) begin
               m_owner <= M_IDLE;
            end else if (m_age + 1 == TO) begin
               m_owner <= M_IDLE;
               m_err   <= 1'b1;
            end else begin
               m_age <= m_age + 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      init_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ens, terr, cke} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL reset_outputs got %b expected 00000", {ens, terr, cke});
      end
      checks++;
      if (pins !== {4'b0001, 2'b10, 13'h0155}) begin
         errors++;
         $display("[TB] FAIL reset_pins got %h expected %h", pins, {4'b0001, 2'b10, 13'h0155});
      end
      rst = 1'b0;
      #1;
      checks++;
      if (cke !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cke_before_edge got %b expected 0", cke);
      end
      step();
      checks++;
      if (cke !== 1'b1) begin
         errors++;
         $display("[TB] FAIL cke_first_edge got %b expected 1", cke);
      end
      repeat (18) step();
      checks++;
      if (pins !== {4'b0001, 2'b10, 13'h0155}) begin
         errors++;
         $display("[TB] FAIL init_pins_c19 got %h expected %h", pins, {4'b0001, 2'b10, 13'h0155});
      end
      step();
      init_done = 1'b1;
      step();
      checks++;
      if (pins !== {4'b0111, 2'b00, 13'h0000} || ens !== 3'b000) begin
         errors++;
         $display("[TB] FAIL arbit_nop_c21 got %h/%b expected %h/000", pins, ens,
                  {4'b0111, 2'b00, 13'h0000});
      end
   endtask

   task automatic test_wr_rd_priority();
      wr_req = 1'b1;
      rd_req = 1'b1;
      step();
      checks++;
      if (ens !== 3'b010 || pins !== {4'b0100, 2'b01, 13'h0ABC}) begin
         errors++;
         $display("[TB] FAIL wr_over_rd got %b/%h expected 010/%h", ens, pins,
                  {4'b0100, 2'b01, 13'h0ABC});
      end
      for (int i = 0; i < 10; i++) begin
         wr_dq_oe = 1'b1;
         wr_data  = 16'(i);
         #1;
         checks++;
         if (dq !== 16'(i) || rd_dq !== 16'(i)) begin
            errors++;
            $display("[TB] FAIL dq_drive_%0d got %h/%h expected %h", i, dq, rd_dq, 16'(i));
         end
         step();
      end
      wr_dq_oe = 1'b0;
      wr_data  = 16'hA5A5;
      #1;
      checks++;
      if (dq === 16'hA5A5) begin
         errors++;
         $display("[TB] FAIL dq_release got %h expected not a5a5", dq);
      end
      wr_done = 1'b1;
      wr_req  = 1'b0;
      step();
      wr_done = 1'b0;
      checks++;
      if (ens !== 3'b000 || pins !== {4'b0111, 2'b00, 13'h0000}) begin
         errors++;
         $display("[TB] FAIL arbit_gap got %b/%h expected 000/nop", ens, pins);
      end
      step();
      checks++;
      if (ens !== 3'b001 || pins !== {4'b0101, 2'b11, 13'h1234}) begin
         errors++;
         $display("[TB] FAIL rd_after_wr got %b/%h expected 001/%h", ens, pins,
                  {4'b0101, 2'b11, 13'h1234});
      end
      rd_done = 1'b1;
      rd_req  = 1'b0;
      step();
      rd_done = 1'b0;
      checks++;
      if (ens !== 3'b000) begin
         errors++;
         $display("[TB] FAIL rd_release got %b expected 000", ens);
      end
   endtask

   task automatic test_aref_mid_write();
      wr_req = 1'b1;
      rd_req = 1'b1;
      step();
      step();
      step();
      aref_req = 1'b1;
      step();
      checks++;
      if (ens !== 3'b010) begin
         errors++;
         $display("[TB] FAIL no_preempt got %b expected 010", ens);
      end
      wr_done = 1'b1;
      wr_req  = 1'b0;
      step();
      wr_done = 1'b0;
      step();
      checks++;
      if (ens !== 3'b100 || pins !== {4'b0001, 2'b00, 13'h0400}) begin
         errors++;
         $display("[TB] FAIL aref_before_rd got %b/%h expected 100/%h", ens, pins,
                  {4'b0001, 2'b00, 13'h0400});
      end
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      checks++;
      if (ens !== 3'b100) begin
         errors++;
         $display("[TB] FAIL foreign_done got %b expected 100", ens);
      end
      aref_done = 1'b1;
      aref_req  = 1'b0;
      step();
      aref_done = 1'b0;
      step();
      checks++;
      if (ens !== 3'b001) begin
         errors++;
         $display("[TB] FAIL rd_after_aref got %b expected 001", ens);
      end
      rd_done = 1'b1;
      rd_req  = 1'b0;
      step();
      rd_done = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      rd_req = 1'b1;
      step();
      n = 0;
      while (rd_en === 1'b1 && n < 100) begin
         step();
         n++;
      end
      rd_req = 1'b0;
      checks++;
      if (n != TO) begin
         errors++;
         $display("[TB] FAIL timeout_len got %0d expected %0d", n, TO);
      end
      checks++;
      if (terr !== 1'b1 || ens !== 3'b000) begin
         errors++;
         $display("[TB] FAIL timeout_flag got %b/%b expected 1/000", terr, ens);
      end
      repeat (3) step();
      checks++;
      if (terr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_sticky got %b expected 1", terr);
      end
   endtask

   task automatic test_init_drop();
      rd_req = 1'b1;
      step();
      init_done = 1'b0;
      step();
      checks++;
      if (ens !== 3'b000 || pins !== {4'b0001, 2'b10, 13'h0155}) begin
         errors++;
         $display("[TB] FAIL init_drop got %b/%h expected 000/%h", ens, pins,
                  {4'b0001, 2'b10, 13'h0155});
      end
      rd_req    = 1'b0;
      init_done = 1'b1;
      step();
      checks++;
      if (pins !== {4'b0111, 2'b00, 13'h0000} || terr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reinit_arbit got %h/%b expected nop/1", pins, terr);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] prev;
      int n;
      prev   = 3'b000;
      wr_req = 1'b1;
      rd_req = 1'b1;
      for (int g = 0; g < 6; g++) begin
         n = 0;
         while (ens === 3'b000 && n < 20) begin
            step();
            n++;
         end
         checks++;
`ifdef SDRAM_ARBIT_RR_EN
         if ((ens !== 3'b010 && ens !== 3'b001) || ens === prev) begin
            errors++;
            $display("[TB] FAIL rr_grant_%0d got %b previous %b expected alternate", g, ens, prev);
         end
`else
         if (ens !== 3'b010) begin
            errors++;
            $display("[TB] FAIL fixed_grant_%0d got %b expected 010", g, ens);
         end
`endif
         prev = ens;
         step();
         step();
         wr_done = prev[1];
         rd_done = prev[0];
         step();
         wr_done = 1'b0;
         rd_done = 1'b0;
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_random();
      rst = 1'b1;
      aref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      aref_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
      step();
      step();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         init_done = ($urandom_range(199) != 0) || (c < 3);
         aref_req  = ($urandom_range(7) == 0);
         wr_req    = $urandom_range(1);
         rd_req    = $urandom_range(1);
         aref_done = ($urandom_range(5) == 0);
         wr_done   = ($urandom_range(5) == 0);
         rd_done   = ($urandom_range(5) == 0);
         wr_dq_oe  = $urandom_range(1);
         wr_data   = 16'($urandom);
         init_cmd  = 4'($urandom);  init_ba = 2'($urandom);  init_addr = 13'($urandom);
         aref_cmd  = 4'($urandom);  aref_ba = 2'($urandom);  aref_addr = 13'($urandom);
         wr_cmd    = 4'($urandom);  wr_ba   = 2'($urandom);  wr_addr   = 13'($urandom);
         rd_cmd    = 4'($urandom);  rd_ba   = 2'($urandom);  rd_addr   = 13'($urandom);
         #1;
         checks++;
         if (pins !== exp_pins) begin
            errors++;
            $display("[TB] FAIL rand_pins c=%0d got %h expected %h", c, pins, exp_pins);
         end
         if (m_owner == M_WR && wr_dq_oe) begin
            checks++;
            if (dq !== wr_data || rd_dq !== wr_data) begin
               errors++;
               $display("[TB] FAIL rand_dq c=%0d got %h/%h expected %h", c, dq, rd_dq, wr_data);
            end
         end else if (wr_data != 16'h0000) begin
            checks++;
            if (dq === wr_data) begin
               errors++;
               $display("[TB] FAIL rand_dq_z c=%0d got %h expected released", c, dq);
            end
         end
         step();
         checks++;
         if ({ens, terr, cke} !== {exp_en, m_err, m_cke}) begin
            errors++;
            $display("[TB] FAIL rand_state c=%0d got %b expected %b", c, {ens, terr, cke},
                     {exp_en, m_err, m_cke});
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      init_done = 1'b0;
      init_cmd = 4'b0001;  init_ba = 2'b10;  init_addr = 13'h0155;
      aref_cmd = 4'b0001;  aref_ba = 2'b00;  aref_addr = 13'h0400;
      wr_cmd   = 4'b0100;  wr_ba   = 2'b01;  wr_addr   = 13'h0ABC;
      rd_cmd   = 4'b0101;  rd_ba   = 2'b11;  rd_addr   = 13'h1234;
      aref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      aref_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
      wr_dq_oe = 1'b0;
      wr_data  = 16'h0000;
      test_reset();
      test_wr_rd_priority();
      test_aref_mid_write();
      test_timeout();
      test_init_drop();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
